// File: rtl/led_p2s_drv.sv
// ---------------------------------------------------------------------------
// led_p2s_drv
//
// Parallel-to-serial driver for daisy-chained LED shift registers. A WIDTH-bit
// LED word is latched at frame start and shifted out on LED_D0, one bit per
// 2*CLK_DIV clk cycles, with a gated serial clock on LED_CLK. Each bit period
// is a low phase of CLK_DIV cycles followed by a high phase of CLK_DIV cycles,
// so data is stable for CLK_DIV cycles on either side of every LED_CLK rising
// edge.
//
// Handshake: there is no ready/valid pair. A frame is requested by a rising
// edge on start (or, with AUTO_REFRESH, by LED differing from the last word
// sent); requests are only looked at while idle and are dropped, not queued,
// while busy. busy is high for exactly the 2*CLK_DIV*WIDTH cycles of the
// frame, and done pulses for one cycle immediately after busy falls.
//
// Ports:
//   clk      in   system clock, rising edge
//   clear    in   synchronous active-high reset; aborts a frame in progress
//   start    in   level input, rising edge requests one frame
//   LED      in   [WIDTH] word to transmit
//   busy     out  high while a frame is being shifted
//   done     out  one-cycle pulse at frame completion
//   LED_CLK  out  serial clock (external registers sample on rising edge)
//   LED_D0   out  serial data
//   LED_CLR  out  active-low clear to the external registers
//   LED_EN   out  output enable to the external registers
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module led_p2s_drv #(
    parameter int WIDTH        = 16,
    parameter int CLK_DIV      = 1,
    parameter bit MSB_FIRST    = 1'b1,
    parameter bit INVERT       = 1'b0,
    parameter bit AUTO_REFRESH = 1'b0
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             start,
    input  logic [WIDTH-1:0] LED,
    output logic             busy,
    output logic             done,
    output logic             LED_CLK,
    output logic             LED_D0,
    output logic             LED_CLR,
    output logic             LED_EN
);

    localparam int BIT_W = $clog2(WIDTH + 1);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state, state_n;
    logic [BIT_W-1:0]   bit_cnt, bit_cnt_n;
    logic [DIV_W-1:0]   div_cnt, div_cnt_n;
    logic [WIDTH-1:0]   shreg, shreg_n;
    logic [WIDTH-1:0]   last_sent, last_sent_n;
    logic               start_q;
    logic               busy_n, done_n, led_clk_n, led_d0_n;

    logic [WIDTH-1:0]   ordered;
    logic [WIDTH-1:0]   load_word;
    logic [WIDTH-1:0]   shift_nxt;
    logic               start_rise;
    logic               trigger;

    // The shift register always sends from its MSB, so the word is reordered
    // at load time for LSB-first operation.
    always_comb begin
        ordered = LED;
        if (!MSB_FIRST) begin
            for (int i = 0; i < WIDTH; i++) begin
                ordered[i] = LED[WIDTH-1-i];
            end
        end
        load_word = INVERT ? ~ordered : ordered;
    end

    assign shift_nxt  = shreg << 1;
    assign start_rise = start & ~start_q;
    // A start edge and an auto-refresh mismatch in the same cycle collapse
    // into a single trigger, so only one frame results.
    assign trigger    = start_rise | (AUTO_REFRESH & (LED != last_sent));

    // Next-state and next-output logic. LED_CLK doubles as the phase flag:
    // low phase first, then high phase, each CLK_DIV cycles long.
    always_comb begin
        state_n     = state;
        bit_cnt_n   = bit_cnt;
        div_cnt_n   = div_cnt;
        shreg_n     = shreg;
        last_sent_n = last_sent;
        busy_n      = busy;
        done_n      = 1'b0;
        led_clk_n   = LED_CLK;
        led_d0_n    = LED_D0;

        case (state)
            IDLE: begin
                busy_n    = 1'b0;
                led_clk_n = 1'b1;
                led_d0_n  = 1'b1;
                if (trigger) begin
                    state_n     = SHIFT;
                    shreg_n     = load_word;
                    last_sent_n = LED;
                    bit_cnt_n   = '0;
                    div_cnt_n   = '0;
                    busy_n      = 1'b1;
                    led_clk_n   = 1'b0;
                    led_d0_n    = load_word[WIDTH-1];
                end
            end

            SHIFT: begin
                if (div_cnt == DIV_LAST) begin
                    div_cnt_n = '0;
                    if (!LED_CLK) begin
                        // End of low phase: raise the serial clock.
                        led_clk_n = 1'b1;
                    end else if (bit_cnt == BIT_LAST) begin
                        // End of the last bit's high phase.
                        state_n   = DONE;
                        busy_n    = 1'b0;
                        done_n    = 1'b1;
                        led_clk_n = 1'b1;
                        led_d0_n  = 1'b1;
                    end else begin
                        // End of high phase: next bit, clock low again.
                        bit_cnt_n = bit_cnt + 1'b1;
                        shreg_n   = shift_nxt;
                        led_clk_n = 1'b0;
                        led_d0_n  = shift_nxt[WIDTH-1];
                    end
                end else begin
                    div_cnt_n = div_cnt + 1'b1;
                end
            end

            DONE: begin
                state_n   = IDLE;
                busy_n    = 1'b0;
                led_clk_n = 1'b1;
                led_d0_n  = 1'b1;
            end

            default: begin
                state_n   = IDLE;
                busy_n    = 1'b0;
                led_clk_n = 1'b1;
                led_d0_n  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            div_cnt   <= '0;
            shreg     <= '0;
            last_sent <= '0;
            // Reset to 1 so a start level held across reset release is not
            // mistaken for a rising edge.
            start_q   <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            LED_CLK   <= 1'b1;
            LED_D0    <= 1'b1;
            LED_CLR   <= 1'b0;
            LED_EN    <= 1'b0;
        end else begin
            state     <= state_n;
            bit_cnt   <= bit_cnt_n;
            div_cnt   <= div_cnt_n;
            shreg     <= shreg_n;
            last_sent <= last_sent_n;
            start_q   <= start;
            busy      <= busy_n;
            done      <= done_n;
            LED_CLK   <= led_clk_n;
            LED_D0    <= led_d0_n;
            LED_CLR   <= 1'b1;
            LED_EN    <= 1'b1;
        end
    end

endmodule

// File: tb/tb_led_p2s_drv.sv
// ---------------------------------------------------------------------------
// tb_led_p2s_drv
//
// Three instances of led_p2s_drv share one clock and one clear:
//   0: WIDTH=16 CLK_DIV=1 MSB first, plain data
//   1: WIDTH=8  CLK_DIV=3 LSB first, inverted data
//   2: WIDTH=16 CLK_DIV=2 MSB first, auto refresh
// The driver pushes the expected serial bit sequence of every frame it causes
// into exp_q; a negedge monitor reconstructs each frame from the pins and pops
// the queue when busy falls.
// ---------------------------------------------------------------------------
module tb_led_p2s_drv;

    localparam int N = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          clear;
    logic [N-1:0]  start_v;
    logic [N-1:0]  busy_v, done_v, lclk_v, ld0_v, lclr_v, len_v;
    logic [15:0]   led_a;
    logic [7:0]    led_b;
    logic [15:0]   led_c;

    // Per-instance configuration as seen by the reference model.
    int width_t[N] = '{16, 8, 16};
    int div_t[N]   = '{1, 3, 2};
    bit msb_t[N]   = '{1'b1, 1'b0, 1'b1};
    bit inv_t[N]   = '{1'b0, 1'b1, 1'b0};

    led_p2s_drv #(.WIDTH(16), .CLK_DIV(1), .MSB_FIRST(1'b1), .INVERT(1'b0), .AUTO_REFRESH(1'b0)) dut_a (
        .clk(clk), .clear(clear), .start(start_v[0]), .LED(led_a),
        .busy(busy_v[0]), .done(done_v[0]), .LED_CLK(lclk_v[0]), .LED_D0(ld0_v[0]),
        .LED_CLR(lclr_v[0]), .LED_EN(len_v[0]));

    led_p2s_drv #(.WIDTH(8), .CLK_DIV(3), .MSB_FIRST(1'b0), .INVERT(1'b1), .AUTO_REFRESH(1'b0)) dut_b (
        .clk(clk), .clear(clear), .start(start_v[1]), .LED(led_b),
        .busy(busy_v[1]), .done(done_v[1]), .LED_CLK(lclk_v[1]), .LED_D0(ld0_v[1]),
        .LED_CLR(lclr_v[1]), .LED_EN(len_v[1]));

    led_p2s_drv #(.WIDTH(16), .CLK_DIV(2), .MSB_FIRST(1'b1), .INVERT(1'b0), .AUTO_REFRESH(1'b1)) dut_c (
        .clk(clk), .clear(clear), .start(start_v[2]), .LED(led_c),
        .busy(busy_v[2]), .done(done_v[2]), .LED_CLK(lclk_v[2]), .LED_D0(ld0_v[2]),
        .LED_CLR(lclr_v[2]), .LED_EN(len_v[2]));

    // ---------------- scoreboard state ----------------
    // Entry = {instance id[3:0], bit sequence[15:0]}; the first bit on the
    // wire sits at position WIDTH-1 of the sequence field.
    logic [19:0] exp_q[$];
    int          checks   = 0;
    int          failures = 0;
    bit          mon_on   = 1'b0;
    bit          abort_exp[N];

    logic        pbusy[N];
    logic        pclk[N];
    logic        pd0[N];
    int          edges[N];
    int          blen[N];
    int          plen[N];
    logic [15:0] acc[N];

    function automatic string nm(input int k, input string s);
        return $sformatf("%s[%0d]", s, k);
    endfunction

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: the order in which bits of the word appear on LED_D0.
    function automatic logic [15:0] frame_bits(input int k, input logic [15:0] word);
        logic [15:0] s;
        int          src;
        s = '0;
        for (int i = 0; i < width_t[k]; i++) begin
            src = msb_t[k] ? (width_t[k] - 1 - i) : i;
            s = {s[14:0], word[src] ^ inv_t[k]};
        end
        return s;
    endfunction

    // ---------------- monitor ----------------
    function automatic void monitor_step(input int k);
        logic        rise;
        logic [19:0] e;
        rise = lclk_v[k] & ~pclk[k];

        if (done_v[k] && !(pbusy[k] && !busy_v[k]))
            check(nm(k, "spurious_done"), 1, 0);

        if (busy_v[k] && !pbusy[k]) begin
            edges[k] = 0;
            acc[k]   = '0;
            blen[k]  = 1;
            plen[k]  = 1;
            check(nm(k, "first_phase_low"), lclk_v[k], 0);
        end else if (busy_v[k] && pbusy[k]) begin
            blen[k]++;
            if ((ld0_v[k] != pd0[k]) && !(pclk[k] && !lclk_v[k]))
                check(nm(k, "d0_change_off_falling_clk"), 1, 0);
            if (lclk_v[k] != pclk[k]) begin
                check(nm(k, "phase_len"), plen[k], div_t[k]);
                plen[k] = 1;
            end else begin
                plen[k]++;
            end
            if (rise) begin
                edges[k]++;
                acc[k] = {acc[k][14:0], ld0_v[k]};
            end
        end else if (!busy_v[k] && pbusy[k]) begin
            if (exp_q.size() == 0) begin
                check(nm(k, "unexpected_frame"), 1, 0);
            end else begin
                e = exp_q.pop_front();
                check(nm(k, "frame_owner"), k, e[19:16]);
                if (abort_exp[k]) begin
                    abort_exp[k] = 1'b0;
                    check(nm(k, "abort_no_done"), done_v[k], 0);
                end else begin
                    check(nm(k, "frame_bits"), acc[k], e[15:0]);
                    check(nm(k, "clk_rises"), edges[k], width_t[k]);
                    check(nm(k, "busy_len"), blen[k], 2 * div_t[k] * width_t[k]);
                    check(nm(k, "last_phase_len"), plen[k], div_t[k]);
                    check(nm(k, "done_pulse"), done_v[k], 1);
                    check(nm(k, "done_clk_high"), lclk_v[k], 1);
                    check(nm(k, "done_d0_high"), ld0_v[k], 1);
                end
            end
        end else begin
            if (rise)
                check(nm(k, "stray_clk_rise"), 1, 0);
        end
    endfunction

    always @(negedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (mon_on)
                monitor_step(k);
            pbusy[k] = busy_v[k];
            pclk[k]  = lclk_v[k];
            pd0[k]   = ld0_v[k];
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_led(input int k, input logic [15:0] w);
        case (k)
            0:       led_a = w;
            1:       led_b = w[7:0];
            default: led_c = w;
        endcase
    endtask

    task automatic pulse_start(input int k, input logic [15:0] w, input logic [19:0] e);
        set_led(k, w);
        start_v[k] = 1'b1;
        exp_q.push_back(e);
        @(negedge clk);
        start_v[k] = 1'b0;
    endtask

    task automatic wait_done(input int k, input int budget);
        int n;
        n = 0;
        while (!done_v[k] && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!done_v[k])
            check(nm(k, "done_timeout"), 0, 1);
        @(negedge clk);
    endtask

    // Global bound so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [15:0] w;
        int          k;
        int          cnt;

        clear   = 1'b1;
        start_v = '0;
        led_a   = '0;
        led_b   = '0;
        led_c   = '0;
        for (int i = 0; i < N; i++) abort_exp[i] = 1'b0;

        // Reset values while clear is held.
        repeat (3) @(negedge clk);
        for (int i = 0; i < N; i++) begin
            check(nm(i, "rst_busy"), busy_v[i], 0);
            check(nm(i, "rst_done"), done_v[i], 0);
            check(nm(i, "rst_led_clk"), lclk_v[i], 1);
            check(nm(i, "rst_led_d0"), ld0_v[i], 1);
            check(nm(i, "rst_led_clr"), lclr_v[i], 0);
            check(nm(i, "rst_led_en"), len_v[i], 0);
        end
        clear = 1'b0;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            check(nm(i, "post_rst_led_clr"), lclr_v[i], 1);
            check(nm(i, "post_rst_led_en"), len_v[i], 1);
        end
        mon_on = 1'b1;

        // 16-bit MSB-first frame of A5C3: sequence 1010010111000011.
        pulse_start(0, 16'hA5C3, {4'd0, 16'hA5C3});
        wait_done(0, 200);

        // 8-bit LSB-first inverted frame of 01: sequence 0,1,1,1,1,1,1,1.
        pulse_start(1, 16'h0001, {4'd1, 16'h007F});
        wait_done(1, 200);

        // Random words on the two start-driven instances.
        for (int r = 0; r < 8; r++) begin
            k = r % 2;
            w = 16'($urandom);
            if (k == 1) w[15:8] = 8'h00;
            pulse_start(k, w, {4'(k), frame_bits(k, w)});
            wait_done(k, 400);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        // Second start edge mid-frame, then start held high through done.
        w = 16'($urandom);
        pulse_start(0, w, {4'd0, frame_bits(0, w)});
        repeat (3) @(negedge clk);
        start_v[0] = 1'b1;
        cnt = 0;
        repeat (60) begin
            @(negedge clk);
            if (done_v[0]) cnt++;
        end
        check("single_done_with_start_held", cnt, 1);
        start_v[0] = 1'b0;
        @(negedge clk);

        // Clear in the middle of a frame; start high across clear release.
        w = 16'($urandom);
        abort_exp[0] = 1'b1;
        pulse_start(0, w, {4'd0, frame_bits(0, w)});
        repeat (9) @(negedge clk);
        clear      = 1'b1;
        start_v[0] = 1'b1;
        @(negedge clk);
        check("abort_busy", busy_v[0], 0);
        check("abort_done", done_v[0], 0);
        check("abort_led_clk", lclk_v[0], 1);
        check("abort_led_d0", ld0_v[0], 1);
        check("abort_led_clr", lclr_v[0], 0);
        check("abort_led_en", len_v[0], 0);
        @(negedge clk);
        clear = 1'b0;
        cnt = 0;
        repeat (50) begin
            @(negedge clk);
            if (busy_v[0]) cnt++;
        end
        check("no_frame_after_clear_release", cnt, 0);
        check("clr_after_release", lclr_v[0], 1);
        start_v[0] = 1'b0;
        @(negedge clk);

        // Auto refresh: zero word after reset sends nothing.
        repeat (20) @(negedge clk);
        check("auto_idle_no_frame", busy_v[2], 0);
        set_led(2, 16'h0001);
        exp_q.push_back({4'd2, 16'h0001});
        @(negedge clk);
        check("auto_start_next_cycle", busy_v[2], 1);
        repeat (10) @(negedge clk);
        set_led(2, 16'h0002);
        exp_q.push_back({4'd2, 16'h0002});
        wait_done(2, 300);
        wait_done(2, 300);

        // Random auto-refresh words, always differing from the current one.
        for (int r = 0; r < 3; r++) begin
            w = 16'($urandom);
            while (w == led_c) w = 16'($urandom);
            set_led(2, w);
            exp_q.push_back({4'd2, frame_bits(2, w)});
            wait_done(2, 300);
        end

        // Start edge and LED change in the same cycle: one frame only.
        w = led_c ^ 16'(1 << $urandom_range(0, 15));
        pulse_start(2, w, {4'd2, frame_bits(2, w)});
        wait_done(2, 300);
        cnt = 0;
        repeat (80) begin
            @(negedge clk);
            if (busy_v[2]) cnt++;
        end
        check("auto_and_start_single_frame", cnt, 0);

        repeat (5) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
